// File: rtl/cpu_pkg.sv
// Shared constants for the CPU data-memory stage: widths, MMIO decode bit and
// the bit layout of the MMIO status word.
package cpu_pkg;

  localparam int unsigned CPU_WIDTH    = 32;
  localparam int unsigned CPU_RAM_AW   = 10;
  localparam int unsigned CPU_FIFO_AW  = 2;
  localparam int unsigned CPU_MMIO_BIT = 31;

  // Status word: {zero, overflow, stall, count[FIFO_AW:0]}
  localparam int unsigned COUNT_LSB = 0;

  typedef enum logic {
    RegionLocal = 1'b0,
    RegionMmio  = 1'b1
  } region_e;

  function automatic int unsigned stall_bit(input int unsigned fifo_aw);
    return fifo_aw + 1;
  endfunction

  function automatic int unsigned ovf_bit(input int unsigned fifo_aw);
    return fifo_aw + 2;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers. A push while full is accepted only
// when a pop frees the head slot in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [2**AW];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = count[AW];
  assign empty = (count == '0);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance; a push into a full FIFO needs a concurrent pop.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q + (AW + 1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW + 1)'(do_pop);
  end

  // Pointer state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents are don't-care until pointed at, so not reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/cpu_data_mem.sv
// Data-memory stage: local word RAM with combinational read, plus an MMIO
// region whose stores are posted through a FIFO to a valid/ready peripheral.
module cpu_data_mem
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH    = CPU_WIDTH,
  parameter int unsigned RAM_AW   = CPU_RAM_AW,
  parameter int unsigned FIFO_AW  = CPU_FIFO_AW,
  parameter int unsigned MMIO_BIT = CPU_MMIO_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] datai,
  input  logic             wmem,
  output logic [WIDTH-1:0] memo,
  output logic             stall,
  output logic             io_valid,
  input  logic             io_ready,
  output logic [WIDTH-1:0] io_addr,
  output logic [WIDTH-1:0] io_data,
  output logic             io_overflow
);

  localparam int unsigned StallBit = stall_bit(FIFO_AW);
  localparam int unsigned OvfBit   = ovf_bit(FIFO_AW);

  logic [WIDTH-1:0]   ram_q [2**RAM_AW];
  logic [RAM_AW-1:0]  idx;
  region_e            region;
  logic               ram_we;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FIFO_AW:0]   fifo_count;
  logic [2*WIDTH-1:0] fifo_head;
  logic [WIDTH-1:0]   status;
  logic               ovf_q, ovf_d;

  // Byte offset and upper non-MMIO bits are ignored, so the RAM aliases.
  assign idx    = addr[RAM_AW+1:2];
  assign region = addr[MMIO_BIT] ? RegionMmio : RegionLocal;

  sync_fifo #(
    .WIDTH (2 * WIDTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({addr, datai}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .rdata (fifo_head)
  );

  assign io_valid    = ~fifo_empty;
  assign io_addr     = fifo_head[2*WIDTH-1:WIDTH];
  assign io_data     = fifo_head[WIDTH-1:0];
  assign stall       = fifo_full;
  assign io_overflow = ovf_q;

  // Region decode, posted-write control and load-data mux.
  always_comb begin
    ram_we    = wmem & (region == RegionLocal);
    fifo_push = wmem & (region == RegionMmio);
    fifo_pop  = io_valid & io_ready;
    // Dropped only when full and the head is not leaving this cycle.
    ovf_d     = ovf_q | (fifo_push & fifo_full & ~fifo_pop);

    status                           = '0;
    status[COUNT_LSB +: FIFO_AW + 1] = fifo_count;
    status[StallBit]                 = fifo_full;
    status[OvfBit]                   = ovf_q;

    memo = (region == RegionMmio) ? status : ram_q[idx];
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  // Local RAM write; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[idx] <= datai;
    end
  end

endmodule
